// File: rtl/updown_dir_ctrl.sv
// Direction controller for a registered up/down counter: synchronises and debounces
// two push-buttons, turns presses into direction changes, optional ping-pong auto-reverse.
module updown_dir_ctrl #(
  parameter int CNT_W     = 3,
  parameter int DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             auto_rev,
  input  logic [CNT_W-1:0] count,
  output logic             ctrl,
  output logic             dir_chg,
  output logic             up_db,
  output logic             down_db
);

  localparam int               DCW     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DCW-1:0]   DB_LAST = DCW'(DB_CYCLES - 1);
  // Reverse one step early: the counter lands on the extreme the same edge ctrl flips.
  localparam logic [CNT_W-1:0] REV_HI  = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] REV_LO  = CNT_W'(1);

  typedef enum logic {S_DOWN = 1'b0, S_UP = 1'b1} state_t;

  // Bit 0 = up button, bit 1 = down button.
  logic [1:0]          w_raw;
  logic [1:0]          r_s1, r_s2, r_db, r_db_q;
  logic [1:0][DCW-1:0] r_dbc;
  logic [1:0]          w_press;
  state_t              r_state, w_next;
  logic                r_dir_chg;

  assign w_raw = {btn_down, btn_up};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_db   <= '0;
      r_db_q <= '0;
      r_dbc  <= '0;
    end else begin
      r_s1   <= w_raw;
      r_s2   <= r_s1;
      r_db_q <= r_db;
      for (int b = 0; b < 2; b++) begin
        if (r_s2[b] != r_db[b]) begin
          if (r_dbc[b] == DB_LAST) begin
            r_db[b]  <= ~r_db[b];
            r_dbc[b] <= '0;
          end else begin
            r_dbc[b] <= r_dbc[b] + 1'b1;
          end
        end else begin
          r_dbc[b] <= '0;
        end
      end
    end
  end

  assign w_press = r_db & ~r_db_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_DOWN;
      r_dir_chg <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_dir_chg <= (w_next != r_state);
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_press[0] && w_press[1])                    w_next = r_state;
    else if (w_press[0])                             w_next = S_UP;
    else if (w_press[1])                             w_next = S_DOWN;
    else if (auto_rev && r_state == S_UP   && count == REV_HI) w_next = S_DOWN;
    else if (auto_rev && r_state == S_DOWN && count == REV_LO) w_next = S_UP;
  end

  always_comb begin
    ctrl    = (r_state == S_UP);
    dir_chg = r_dir_chg;
    up_db   = r_db[0];
    down_db = r_db[1];
  end

endmodule
